// File: rtl/vending_pkg.sv
// Shared vending definitions: cents width, coin values, dispenser encodings.
package vending_pkg;

  localparam int CENTS_W = 8;

  localparam logic [CENTS_W-1:0] COIN_Q = 8'd25;
  localparam logic [CENTS_W-1:0] COIN_D = 8'd10;
  localparam logic [CENTS_W-1:0] COIN_N = 8'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } disp_state_t;

  typedef enum logic [1:0] {
    COIN_NONE  = 2'd0,
    COIN_SEL_Q = 2'd1,
    COIN_SEL_D = 2'd2,
    COIN_SEL_N = 2'd3
  } coin_sel_t;

  // Cent value of a coin selection; COIN_NONE is worth nothing.
  function automatic logic [CENTS_W-1:0] coin_value(input coin_sel_t sel);
    logic [CENTS_W-1:0] val;
    val = '0;
    case (sel)
      COIN_SEL_Q: val = COIN_Q;
      COIN_SEL_D: val = COIN_D;
      COIN_SEL_N: val = COIN_N;
      default:    val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_stock_counter.sv
// Per-hopper coin stock: loads INIT on clr/reload, counts down once per coin
// paid, and never wraps below zero.
module coin_stock_counter
  import vending_pkg::*;
#(
  parameter int unsigned INIT = 20
) (
  input  logic clk,
  input  logic clr,
  input  logic reload,
  input  logic dec,
  output logic empty
);

  localparam logic [CENTS_W-1:0] INIT_V = CENTS_W'(INIT);

  logic [CENTS_W-1:0] count_q;
  logic [CENTS_W-1:0] count_d;

  // Next stock: reload has priority over a decrement; zero is sticky.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = INIT_V;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 8'd1;
    end
  end

  // Stock register with synchronous clear back to INIT.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= INIT_V;
    end else begin
      count_q <= count_d;
    end
  end

  assign empty = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: pays a loaded cent amount as quarter/dime/nickel
// pulses, largest coin first, falling back when a hopper is empty.
// Handshake: change_load is a one-cycle strobe accepted only while busy is
// low (IDLE); done pulses for one cycle at the end of every accepted load.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned INIT_Q     = 20,
  parameter int unsigned INIT_D     = 20,
  parameter int unsigned INIT_N     = 20
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               change_load,
  input  logic [CENTS_W-1:0] change_in,
  input  logic               restock,
  output logic               quarter_out,
  output logic               dime_out,
  output logic               nickel_out,
  output logic               busy,
  output logic               done,
  output logic               short_change,
  output logic [CENTS_W-1:0] remaining,
  output logic [CENTS_W-1:0] dispensed,
  output logic               q_empty,
  output logic               d_empty,
  output logic               n_empty,
  output disp_state_t        dbg_state
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  disp_state_t        state_q, state_d;
  coin_sel_t          sel_q, sel_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic [CENTS_W-1:0] remaining_q, remaining_d;
  logic [CENTS_W-1:0] dispensed_q, dispensed_d;
  logic               short_q, short_d;

  logic reload;
  logic dec_q, dec_d, dec_n;

  // Stocks only reload between transactions; a coin is consumed as its pulse ends.
  assign reload = restock && (state_q == ST_IDLE);
  assign dec_q  = (state_q == ST_PULSE) && (sel_q == COIN_SEL_Q);
  assign dec_d  = (state_q == ST_PULSE) && (sel_q == COIN_SEL_D);
  assign dec_n  = (state_q == ST_PULSE) && (sel_q == COIN_SEL_N);

  coin_stock_counter #(.INIT(INIT_Q)) u_q_stock (
    .clk(clk), .clr(clr), .reload(reload), .dec(dec_q), .empty(q_empty)
  );
  coin_stock_counter #(.INIT(INIT_D)) u_d_stock (
    .clk(clk), .clr(clr), .reload(reload), .dec(dec_d), .empty(d_empty)
  );
  coin_stock_counter #(.INIT(INIT_N)) u_n_stock (
    .clk(clk), .clr(clr), .reload(reload), .dec(dec_n), .empty(n_empty)
  );

  // Next-state, coin selection and payout bookkeeping.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gap_cnt_d   = gap_cnt_q;
    remaining_d = remaining_q;
    dispensed_d = dispensed_q;
    short_d     = short_q;
    case (state_q)
      ST_IDLE: begin
        if (change_load) begin
          state_d     = ST_SELECT;
          remaining_d = change_in;
          dispensed_d = '0;
          short_d     = 1'b0;
        end
      end
      ST_SELECT: begin
        state_d = ST_PULSE;
        if ((remaining_q >= COIN_Q) && !q_empty) begin
          sel_d = COIN_SEL_Q;
        end else if ((remaining_q >= COIN_D) && !d_empty) begin
          sel_d = COIN_SEL_D;
        end else if ((remaining_q >= COIN_N) && !n_empty) begin
          sel_d = COIN_SEL_N;
        end else begin
          sel_d   = COIN_NONE;
          state_d = ST_DONE;
          short_d = (remaining_q != '0);
        end
      end
      ST_PULSE: begin
        remaining_d = remaining_q - coin_value(sel_q);
        dispensed_d = dispensed_q + coin_value(sel_q);
        sel_d       = COIN_NONE;
        gap_cnt_d   = '0;
        state_d     = (GAP_CYCLES == 0) ? ST_SELECT : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_SELECT;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      sel_q       <= COIN_NONE;
      gap_cnt_q   <= '0;
      remaining_q <= '0;
      dispensed_q <= '0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gap_cnt_q   <= gap_cnt_d;
      remaining_q <= remaining_d;
      dispensed_q <= dispensed_d;
      short_q     <= short_d;
    end
  end

  assign quarter_out  = (state_q == ST_PULSE) && (sel_q == COIN_SEL_Q);
  assign dime_out     = (state_q == ST_PULSE) && (sel_q == COIN_SEL_D);
  assign nickel_out   = (state_q == ST_PULSE) && (sel_q == COIN_SEL_N);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign short_change = short_q;
  assign remaining    = remaining_q;
  assign dispensed    = dispensed_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: four instances cover the default,
// zero-gap, single-quarter and no-dime/no-nickel configurations.
module tb_change_dispenser;
  import vending_pkg::*;

  logic clk;
  logic clr;
  logic       load_i[4];
  logic       restock_i[4];
  logic [7:0] cin_i[4];
  logic       q_o[4], d_o[4], n_o[4], busy_o[4], done_o[4], short_o[4];
  logic [7:0] rem_o[4], disp_o[4];
  logic       qe_o[4], de_o[4], ne_o[4];
  disp_state_t st_o[4];

  int checks = 0;
  int errors = 0;

  int         p_edge[$];
  logic [7:0] p_val[$];
  int         exp_edge_q[$];
  logic [7:0] exp_q[$];
  int         done_edge;

  // Clock and reset drivers
  initial clk = 1'b0;
  always #5 clk = ~clk;

  change_dispenser dut_a (
    .clk(clk), .clr(clr), .change_load(load_i[0]), .change_in(cin_i[0]),
    .restock(restock_i[0]), .quarter_out(q_o[0]), .dime_out(d_o[0]),
    .nickel_out(n_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .short_change(short_o[0]), .remaining(rem_o[0]), .dispensed(disp_o[0]),
    .q_empty(qe_o[0]), .d_empty(de_o[0]), .n_empty(ne_o[0]), .dbg_state(st_o[0])
  );

  change_dispenser #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .clr(clr), .change_load(load_i[1]), .change_in(cin_i[1]),
    .restock(restock_i[1]), .quarter_out(q_o[1]), .dime_out(d_o[1]),
    .nickel_out(n_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .short_change(short_o[1]), .remaining(rem_o[1]), .dispensed(disp_o[1]),
    .q_empty(qe_o[1]), .d_empty(de_o[1]), .n_empty(ne_o[1]), .dbg_state(st_o[1])
  );

  change_dispenser #(.INIT_Q(1)) dut_c (
    .clk(clk), .clr(clr), .change_load(load_i[2]), .change_in(cin_i[2]),
    .restock(restock_i[2]), .quarter_out(q_o[2]), .dime_out(d_o[2]),
    .nickel_out(n_o[2]), .busy(busy_o[2]), .done(done_o[2]),
    .short_change(short_o[2]), .remaining(rem_o[2]), .dispensed(disp_o[2]),
    .q_empty(qe_o[2]), .d_empty(de_o[2]), .n_empty(ne_o[2]), .dbg_state(st_o[2])
  );

  change_dispenser #(.INIT_D(0), .INIT_N(0)) dut_d (
    .clk(clk), .clr(clr), .change_load(load_i[3]), .change_in(cin_i[3]),
    .restock(restock_i[3]), .quarter_out(q_o[3]), .dime_out(d_o[3]),
    .nickel_out(n_o[3]), .busy(busy_o[3]), .done(done_o[3]),
    .short_change(short_o[3]), .remaining(rem_o[3]), .dispensed(disp_o[3]),
    .q_empty(qe_o[3]), .d_empty(de_o[3]), .n_empty(ne_o[3]), .dbg_state(st_o[3])
  );

  // Comparison helpers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [7:0] amt, input logic rs);
    cin_i[idx]     = amt;
    load_i[idx]    = 1'b1;
    restock_i[idx] = rs;
    step();
    load_i[idx]    = 1'b0;
    restock_i[idx] = 1'b0;
  endtask

  // Steps from E0 until done, logging every coin pulse with its edge index.
  task automatic collect(input int idx, input logic [7:0] amount, input int budget);
    p_edge.delete();
    p_val.delete();
    done_edge = -1;
    for (int e = 1; e <= budget; e++) begin
      step();
      chk8("paid_plus_owed", disp_o[idx] + rem_o[idx], amount);
      if (q_o[idx]) begin p_edge.push_back(e); p_val.push_back(8'd25); end
      if (d_o[idx]) begin p_edge.push_back(e); p_val.push_back(8'd10); end
      if (n_o[idx]) begin p_edge.push_back(e); p_val.push_back(8'd5);  end
      if (done_o[idx]) begin
        done_edge = e;
        break;
      end
    end
  endtask

  // Scoreboard: logged pulses against the expected queue.
  task automatic check_pulses(input string tag, input int exp_done);
    chk32({tag, "_npulse"}, p_edge.size(), exp_edge_q.size());
    for (int i = 0; i < exp_edge_q.size() && i < p_edge.size(); i++) begin
      chk32({tag, "_edge"}, p_edge[i], exp_edge_q[i]);
      chk8({tag, "_coin"}, p_val[i], exp_q[i]);
    end
    chk32({tag, "_done_edge"}, done_edge, exp_done);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      load_i[i]    = 1'b0;
      restock_i[i] = 1'b0;
      cin_i[i]     = 8'd0;
    end
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) begin
      chk32("rst_state", int'(st_o[i]), int'(ST_IDLE));
      chk1("rst_busy", busy_o[i], 1'b0);
      chk1("rst_done", done_o[i], 1'b0);
      chk1("rst_short", short_o[i], 1'b0);
      chk1("rst_pulse", q_o[i] | d_o[i] | n_o[i], 1'b0);
      chk8("rst_rem", rem_o[i], 8'd0);
      chk8("rst_disp", disp_o[i], 8'd0);
      chk1("rst_q_empty", qe_o[i], 1'b0);
    end
    chk1("rst_a_d_empty", de_o[0], 1'b0);
    chk1("rst_d_d_empty", de_o[3], 1'b1);
    chk1("rst_d_n_empty", ne_o[3], 1'b1);

    // Defaults, 30 cents: quarter E1, nickel E5, done E9
    load(0, 8'd30, 1'b0);
    chk32("t30_select", int'(st_o[0]), int'(ST_SELECT));
    chk1("t30_busy", busy_o[0], 1'b1);
    collect(0, 8'd30, 20);
    exp_edge_q = '{1, 5};
    exp_q      = '{8'd25, 8'd5};
    check_pulses("t30", 9);
    chk8("t30_disp", disp_o[0], 8'd30);
    chk8("t30_rem", rem_o[0], 8'd0);
    step();
    chk1("t30_busy_low", busy_o[0], 1'b0);
    chk1("t30_short", short_o[0], 1'b0);

    // Zero gap, 95 cents: Q,Q,Q,D,D back to back, done E11
    load(1, 8'd95, 1'b0);
    collect(1, 8'd95, 20);
    exp_edge_q = '{1, 3, 5, 7, 9};
    exp_q      = '{8'd25, 8'd25, 8'd25, 8'd10, 8'd10};
    check_pulses("t95", 11);
    chk8("t95_q_stock", dut_b.u_q_stock.count_q, 8'd17);
    chk8("t95_d_stock", dut_b.u_d_stock.count_q, 8'd18);
    chk8("t95_n_stock", dut_b.u_n_stock.count_q, 8'd20);

    // One quarter in stock, 50 cents: Q,D,D,N
    load(2, 8'd50, 1'b0);
    collect(2, 8'd50, 30);
    exp_edge_q = '{1, 5, 9, 13};
    exp_q      = '{8'd25, 8'd10, 8'd10, 8'd5};
    check_pulses("t50", 17);
    chk1("t50_q_empty", qe_o[2], 1'b1);
    chk8("t50_disp", disp_o[2], 8'd50);
    step();
    chk1("t50_short", short_o[2], 1'b0);

    // Restock on the load edge: first SELECT already sees a quarter
    load(2, 8'd25, 1'b1);
    chk1("trs_q_restored", qe_o[2], 1'b0);
    collect(2, 8'd25, 10);
    exp_edge_q = '{1};
    exp_q      = '{8'd25};
    check_pulses("trs", 5);
    chk8("trs_d_stock", dut_c.u_d_stock.count_q, 8'd20);
    step();

    // 7 cents: one nickel, 2 cents short
    load(0, 8'd7, 1'b0);
    collect(0, 8'd7, 10);
    exp_edge_q = '{1};
    exp_q      = '{8'd5};
    check_pulses("t7", 5);
    step();
    chk1("t7_short", short_o[0], 1'b1);
    chk8("t7_rem", rem_o[0], 8'd2);
    chk8("t7_disp", disp_o[0], 8'd5);

    // Zero owed: short clears on load, done at E1, no coins
    load(0, 8'd0, 1'b0);
    chk1("t0_short_cleared", short_o[0], 1'b0);
    chk8("t0_rem", rem_o[0], 8'd0);
    collect(0, 8'd0, 4);
    exp_edge_q = '{};
    exp_q      = '{};
    check_pulses("t0", 1);
    step();
    chk1("t0_short", short_o[0], 1'b0);

    // No dimes or nickels, 15 cents: nothing payable
    load(3, 8'd15, 1'b0);
    collect(3, 8'd15, 4);
    check_pulses("t15", 1);
    step();
    chk1("t15_short", short_o[3], 1'b1);
    chk8("t15_rem", rem_o[3], 8'd15);
    chk8("t15_disp", disp_o[3], 8'd0);

    // 60 cents: load and restock during the gap are ignored, then clr
    load(0, 8'd60, 1'b0);
    step();
    chk1("t60_p1", q_o[0], 1'b1);
    step();
    chk32("t60_gap", int'(st_o[0]), int'(ST_GAP));
    cin_i[0]     = 8'd99;
    load_i[0]    = 1'b1;
    restock_i[0] = 1'b1;
    step();
    load_i[0]    = 1'b0;
    restock_i[0] = 1'b0;
    chk32("t60_still_gap", int'(st_o[0]), int'(ST_GAP));
    chk8("t60_rem_kept", rem_o[0], 8'd35);
    chk8("t60_disp_kept", disp_o[0], 8'd25);
    chk8("t60_no_restock", dut_a.u_q_stock.count_q, 8'd18);
    step();
    step();
    chk1("t60_p2", q_o[0], 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk32("clr_state", int'(st_o[0]), int'(ST_IDLE));
    chk1("clr_pulse", q_o[0] | d_o[0] | n_o[0], 1'b0);
    chk1("clr_busy", busy_o[0], 1'b0);
    chk1("clr_done", done_o[0], 1'b0);
    chk1("clr_short", short_o[0], 1'b0);
    chk8("clr_rem", rem_o[0], 8'd0);
    chk8("clr_disp", disp_o[0], 8'd0);
    chk8("clr_q_stock", dut_a.u_q_stock.count_q, 8'd20);
    chk8("clr_d_stock", dut_a.u_d_stock.count_q, 8'd20);
    chk8("clr_n_stock", dut_a.u_n_stock.count_q, 8'd20);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
